// File: rtl/psg_audio_pkg.sv
// Shared types and helpers for the PSG audio mixer.
// Contents: stereo mode / FSM state enums, mix/lowpass/DC-blocker sample
// types, and the 16-bit signed saturation helper.
package psg_audio_pkg;

  localparam int unsigned MIX_W = 10;  // 3 x 8-bit levels, max 765
  localparam int unsigned LP_W  = 18;  // 10.8 unsigned lowpass state
  localparam int unsigned DC_W  = 20;  // signed, 8 fraction bits
  localparam int unsigned AUD_W = 16;

  typedef enum logic [1:0] {
    MONO = 2'd0,
    ABC  = 2'd1,
    ACB  = 2'd2
  } stereo_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC_L = 2'd1,
    S_CALC_R = 2'd2,
    S_OUT    = 2'd3
  } fsm_state_e;

  typedef logic        [MIX_W-1:0] mix_t;
  typedef logic        [LP_W-1:0]  lp_t;
  typedef logic signed [DC_W-1:0]  dc_t;
  typedef logic signed [AUD_W-1:0] aud_t;

  // Clamp a wide signed value into the 16-bit signed range.
  function automatic aud_t sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end
    return aud_t'(v);
  endfunction

endpackage

// File: rtl/psg_lp1.sv
// One-pole lowpass: lp += (x - lp) >>> LP_SHIFT, x = {mix, 8'b0}.
// Ports: CLK, RESET_N (async, active low), CE (update strobe),
//        mix_i (10-bit unsigned input), lp_o (18-bit 10.8 state).
module psg_lp1
  import psg_audio_pkg::*;
#(
  parameter int unsigned LP_SHIFT = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic CE,
  input  mix_t mix_i,
  output lp_t  lp_o
);

  lp_t lp_q, lp_d;
  logic signed [LP_W:0] x_s, lp_s, diff_s, sum_s;

  // Signed 19-bit update; the result never leaves the unsigned 18-bit range.
  always_comb begin
    x_s    = $signed({1'b0, mix_i, 8'h00});
    lp_s   = $signed({1'b0, lp_q});
    diff_s = x_s - lp_s;
    sum_s  = lp_s + (diff_s >>> LP_SHIFT);
    lp_d   = lp_q;
    if (CE) begin
      lp_d = lp_t'(sum_s);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lp_q <= '0;
    end else begin
      lp_q <= lp_d;
    end
  end

  assign lp_o = lp_q;

endmodule

// File: rtl/psg_audio_mixer.sv
// PSG audio mixer: three 8-bit channel levels -> signed 16-bit stereo sample.
// Mix (mono/ABC/ACB) and lowpass run on CE; a shared DC blocker and the
// output stage run once per accepted SAMPLE_CE via a 4-state sequencer.
// Ports: CLK, RESET_N (async, active low), CE, CH_A/CH_B/CH_C, STEREO, MUTE,
//        SAMPLE_CE in; AUDIO_L/AUDIO_R, SAMPLE_VALID, OVERRUN out.
module psg_audio_mixer
  import psg_audio_pkg::*;
#(
  parameter int unsigned LP_SHIFT  = 4,
  parameter int unsigned DC_SHIFT  = 10,
  parameter int unsigned OUT_SHIFT = 5,
  parameter bit          DC_EN     = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CE,
  input  logic [7:0]        CH_A,
  input  logic [7:0]        CH_B,
  input  logic [7:0]        CH_C,
  input  logic [1:0]        STEREO,
  input  logic              MUTE,
  input  logic              SAMPLE_CE,
  output logic signed [15:0] AUDIO_L,
  output logic signed [15:0] AUDIO_R,
  output logic              SAMPLE_VALID,
  output logic              OVERRUN
);

  mix_t       ch_a_w, ch_b_w, ch_c_w;
  mix_t       mix_l_q, mix_r_q, mix_l_d, mix_r_d;
  lp_t        lp_l, lp_r;
  fsm_state_e state_q, state_d;
  lp_t        xl_q, xl_d, xr_q, xr_d;
  lp_t        xl_prev_q, xl_prev_d, xr_prev_q, xr_prev_d;
  dc_t        yl_q, yl_d, yr_q, yr_d;
  aud_t       audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic       valid_q, valid_d;
  logic       overrun_c;
  lp_t        x_sel, xp_sel;
  dc_t        y_sel, y_new, src_l, src_r;

  // Integer part of a filter value, scaled and saturated to 16 bits.
  function automatic aud_t scale_out(input dc_t v);
    logic signed [31:0] t;
    t = 32'(v);
    t = (t >>> 8) <<< OUT_SHIFT;
    return sat16(t);
  endfunction

  // Channel mix per panning mode; STEREO = 3 falls back to mono.
  always_comb begin
    ch_a_w  = mix_t'(CH_A);
    ch_b_w  = mix_t'(CH_B);
    ch_c_w  = mix_t'(CH_C);
    mix_l_d = ch_a_w + ch_b_w + ch_c_w;
    mix_r_d = mix_l_d;
    case (STEREO)
      ABC: begin
        mix_l_d = (ch_a_w << 1) + ch_b_w;
        mix_r_d = (ch_c_w << 1) + ch_b_w;
      end
      ACB: begin
        mix_l_d = (ch_a_w << 1) + ch_c_w;
        mix_r_d = (ch_b_w << 1) + ch_c_w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mix_l_q <= '0;
      mix_r_q <= '0;
    end else if (CE) begin
      mix_l_q <= mix_l_d;
      mix_r_q <= mix_r_d;
    end
  end

  psg_lp1 #(.LP_SHIFT(LP_SHIFT)) u_lp_l (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .mix_i   (mix_l_q),
    .lp_o    (lp_l)
  );

  psg_lp1 #(.LP_SHIFT(LP_SHIFT)) u_lp_r (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .CE      (CE),
    .mix_i   (mix_r_q),
    .lp_o    (lp_r)
  );

  // Shared DC-blocker datapath: right channel in CALC_R, left otherwise.
  always_comb begin
    x_sel  = (state_q == S_CALC_R) ? xr_q      : xl_q;
    xp_sel = (state_q == S_CALC_R) ? xr_prev_q : xl_prev_q;
    y_sel  = (state_q == S_CALC_R) ? yr_q      : yl_q;
    y_new  = dc_t'({2'b00, x_sel}) - dc_t'({2'b00, xp_sel}) + y_sel
             - (y_sel >>> DC_SHIFT);
    src_l  = DC_EN ? yl_q  : dc_t'({2'b00, xl_q});
    src_r  = DC_EN ? y_new : dc_t'({2'b00, xr_q});
  end

  // Sequencer. The output registers load on entry to OUT so AUDIO_L/R and
  // SAMPLE_VALID are visible during the OUT cycle. OVERRUN is decoded
  // directly so it flags the very cycle of the dropped request.
  always_comb begin
    state_d   = state_q;
    xl_d      = xl_q;
    xr_d      = xr_q;
    xl_prev_d = xl_prev_q;
    xr_prev_d = xr_prev_q;
    yl_d      = yl_q;
    yr_d      = yr_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    overrun_c = SAMPLE_CE && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (SAMPLE_CE) begin
          xl_d    = lp_l;
          xr_d    = lp_r;
          state_d = S_CALC_L;
        end
      end
      S_CALC_L: begin
        yl_d      = y_new;
        xl_prev_d = xl_q;
        state_d   = S_CALC_R;
      end
      S_CALC_R: begin
        yr_d      = y_new;
        xr_prev_d = xr_q;
        audio_l_d = MUTE ? '0 : scale_out(src_l);
        audio_r_d = MUTE ? '0 : scale_out(src_r);
        valid_d   = 1'b1;
        state_d   = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      xl_q      <= '0;
      xr_q      <= '0;
      xl_prev_q <= '0;
      xr_prev_q <= '0;
      yl_q      <= '0;
      yr_q      <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      xl_q      <= xl_d;
      xr_q      <= xr_d;
      xl_prev_q <= xl_prev_d;
      xr_prev_q <= xr_prev_d;
      yl_q      <= yl_d;
      yr_q      <= yr_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
    end
  end

  assign AUDIO_L      = audio_l_q;
  assign AUDIO_R      = audio_r_q;
  assign SAMPLE_VALID = valid_q;
  assign OVERRUN      = overrun_c;

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Bench for psg_audio_mixer: four parameter variants driven by shared
// stimulus, compared cycle by cycle against an arithmetic reference model.
module tb_psg_audio_mixer;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic        sce;
  logic        mute;
  logic [1:0]  stereo;
  logic [7:0]  ch_a, ch_b, ch_c;

  logic signed [15:0] aud_l [4];
  logic signed [15:0] aud_r [4];
  logic               vld   [4];
  logic               ovr   [4];

  int n_checks;
  int n_errors;
  int ovr_cnt;

  // Variant table: 0 = default, 1 = DC bypass, 2 = bypass x64, 3 = DC x64.
  function automatic int osh(input int i);
    return (i >= 2) ? 6 : 5;
  endfunction
  function automatic bit dce(input int i);
    return (i == 0) || (i == 3);
  endfunction

  psg_audio_mixer u_dc (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .SAMPLE_CE(sce), .AUDIO_L(aud_l[0]),
    .AUDIO_R(aud_r[0]), .SAMPLE_VALID(vld[0]), .OVERRUN(ovr[0]));

  psg_audio_mixer #(.DC_EN(1'b0)) u_nodc (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .SAMPLE_CE(sce), .AUDIO_L(aud_l[1]),
    .AUDIO_R(aud_r[1]), .SAMPLE_VALID(vld[1]), .OVERRUN(ovr[1]));

  psg_audio_mixer #(.OUT_SHIFT(6), .DC_EN(1'b0)) u_sat (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .SAMPLE_CE(sce), .AUDIO_L(aud_l[2]),
    .AUDIO_R(aud_r[2]), .SAMPLE_VALID(vld[2]), .OVERRUN(ovr[2]));

  psg_audio_mixer #(.OUT_SHIFT(6), .DC_EN(1'b1)) u_satdc (
    .CLK(clk), .RESET_N(rst_n), .CE(ce), .CH_A(ch_a), .CH_B(ch_b), .CH_C(ch_c),
    .STEREO(stereo), .MUTE(mute), .SAMPLE_CE(sce), .AUDIO_L(aud_l[3]),
    .AUDIO_R(aud_r[3]), .SAMPLE_VALID(vld[3]), .OVERRUN(ovr[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state (plain integers).
  int m_mix_l, m_mix_r, m_lp_l, m_lp_r, m_busy;
  int m_y_l [4];
  int m_y_r [4];
  int m_xp_l[4];
  int m_xp_r[4];
  int m_pend_l[4];
  int m_pend_r[4];
  int m_exp_l[4];
  int m_exp_r[4];
  bit m_valid;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mix_of(input bit right, input int mode, input int a,
                                input int b, input int c);
    case (mode)
      1:       return right ? 2 * c + b : 2 * a + b;
      2:       return right ? 2 * b + c : 2 * a + c;
      default: return a + b + c;
    endcase
  endfunction

  function automatic int out_of(input int v, input int sh);
    int r;
    r = (v >>> 8) * (1 << sh);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model_reset();
    m_mix_l = 0; m_mix_r = 0; m_lp_l = 0; m_lp_r = 0; m_busy = 0; m_valid = 0;
    for (int i = 0; i < 4; i++) begin
      m_y_l[i] = 0; m_y_r[i] = 0; m_xp_l[i] = 0; m_xp_r[i] = 0;
      m_pend_l[i] = 0; m_pend_r[i] = 0; m_exp_l[i] = 0; m_exp_r[i] = 0;
    end
  endtask

  // One clock edge of behaviour: sample request first (pre-update lp), then CE.
  task automatic model_edge();
    m_valid = 0;
    if (m_busy == 0) begin
      if (sce) begin
        for (int i = 0; i < 4; i++) begin
          m_y_l[i]  = m_lp_l - m_xp_l[i] + m_y_l[i] - (m_y_l[i] >>> 10);
          m_y_r[i]  = m_lp_r - m_xp_r[i] + m_y_r[i] - (m_y_r[i] >>> 10);
          m_xp_l[i] = m_lp_l;
          m_xp_r[i] = m_lp_r;
          m_pend_l[i] = out_of(dce(i) ? m_y_l[i] : m_lp_l, osh(i));
          m_pend_r[i] = out_of(dce(i) ? m_y_r[i] : m_lp_r, osh(i));
        end
        m_busy = 3;
      end
    end else begin
      m_busy--;
      if (m_busy == 1) begin
        m_valid = 1;
        for (int i = 0; i < 4; i++) begin
          m_exp_l[i] = mute ? 0 : m_pend_l[i];
          m_exp_r[i] = mute ? 0 : m_pend_r[i];
        end
      end
    end
    if (ce) begin
      m_lp_l  = m_lp_l + ((m_mix_l * 256 - m_lp_l) >>> 4);
      m_lp_r  = m_lp_r + ((m_mix_r * 256 - m_lp_r) >>> 4);
      m_mix_l = mix_of(1'b0, int'(stereo), int'(ch_a), int'(ch_b), int'(ch_c));
      m_mix_r = mix_of(1'b1, int'(stereo), int'(ch_a), int'(ch_b), int'(ch_c));
    end
  endtask

  // One clock: OVERRUN checked mid-cycle, outputs checked 1 after the edge.
  task automatic tick();
    if (!rst_n) model_reset();
    #4;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("overrun%0d", i), int'(ovr[i]),
            (sce && m_busy != 0 && rst_n) ? 1 : 0);
    end
    ovr_cnt += int'(ovr[0]);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid%0d", i), int'(vld[i]), int'(m_valid));
      check($sformatf("audio_l%0d", i), int'(aud_l[i]), m_exp_l[i]);
      check($sformatf("audio_r%0d", i), int'(aud_r[i]), m_exp_r[i]);
    end
  endtask

  function automatic bit near(input int v, input int target, input int tol);
    return (v >= target - tol) && (v <= target + tol);
  endfunction

  initial begin
    int nv;
    int ov0;
    int prev_l;
    n_checks = 0; n_errors = 0; ovr_cnt = 0;
    rst_n = 1'b0; ce = 1'b0; sce = 1'b0; mute = 1'b0; stereo = 2'd0;
    ch_a = 8'd0; ch_b = 8'd0; ch_c = 8'd0;
    model_reset();

    // Reset state, then a sample every 64 clocks with random levels.
    repeat (4) tick();
    check("reset_audio_l", int'(aud_l[0]), 0);
    rst_n = 1'b1;
    for (int s = 0; s < 8; s++) begin
      for (int k = 0; k < 64; k++) begin
        ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom);
        stereo = 2'($urandom_range(0, 3));
        ce = 1'($urandom_range(0, 1));
        sce = (k == 0);
        tick();
      end
    end

    // Mono full scale, CE every clock.
    stereo = 2'd0; ch_a = 8'd255; ch_b = 8'd255; ch_c = 8'd255; ce = 1'b1;
    for (int k = 0; k < 400; k++) begin
      sce = (k % 64 == 0);
      tick();
    end
    sce = 1'b0;
    check("mono_settle_l", int'(near(int'(aud_l[1]), 24480, 32)), 1);
    check("mono_settle_r", int'(near(int'(aud_r[1]), 24480, 32)), 1);
    check("mono_sat_l", int'(aud_l[2]), 32767);

    // ABC with only A, then ACB with B added.
    stereo = 2'd1; ch_a = 8'd255; ch_b = 8'd0; ch_c = 8'd0;
    for (int k = 0; k < 400; k++) begin
      sce = (k % 64 == 0);
      tick();
    end
    check("abc_l", int'(near(int'(aud_l[1]), 16320, 32)), 1);
    check("abc_r", int'(aud_r[1]), 0);
    stereo = 2'd2; ch_b = 8'd255;
    for (int k = 0; k < 400; k++) begin
      sce = (k % 64 == 0);
      tick();
    end
    check("acb_r", int'(near(int'(aud_r[1]), 16320, 32)), 1);

    // DC blocker step response from a clean reset.
    rst_n = 1'b0; sce = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1; stereo = 2'd0; ch_a = 8'd0; ch_b = 8'd0; ch_c = 8'd0;
    repeat (8) tick();
    ch_a = 8'd255; ch_b = 8'd255; ch_c = 8'd255;
    prev_l = 32767;
    for (int k = 0; k < 28000; k++) begin
      sce = (k % 4 == 0);
      tick();
      if (k == 240) begin
        check("dc_step_up", int'(aud_l[0] > 16'sd22000), 1);
        check("dc_sat_pos", int'(aud_l[3]), 32767);
      end
      if (m_valid && k >= 240) begin
        check("dc_decay_mono", int'(int'(aud_l[0]) <= prev_l), 1);
        prev_l = int'(aud_l[0]);
      end
    end
    check("dc_decayed", int'(aud_l[0] >= 16'sd0 && aud_l[0] <= 16'sd96), 1);
    ch_a = 8'd0; ch_b = 8'd0; ch_c = 8'd0;
    for (int k = 0; k < 400; k++) begin
      sce = (k % 4 == 0);
      tick();
      if (k == 240) begin
        check("dc_step_down", int'(aud_l[0] < -16'sd21000), 1);
        check("dc_sat_neg", int'(aud_l[3]), -32768);
      end
    end

    // Back-to-back SAMPLE_CE: one OVERRUN, one SAMPLE_VALID.
    sce = 1'b0;
    repeat (4) tick();
    ch_a = 8'($urandom); ch_b = 8'($urandom);
    nv = 0; ov0 = ovr_cnt;
    sce = 1'b1; tick();
    sce = 1'b1; tick();
    sce = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      nv += int'(vld[0]);
    end
    check("ovr_pulses", ovr_cnt - ov0, 1);
    check("ovr_one_valid", nv, 1);

    // Same pattern, aborted by reset mid-calculation.
    nv = 0;
    sce = 1'b1; tick(); nv += int'(vld[0]);
    sce = 1'b1; tick(); nv += int'(vld[0]);
    sce = 1'b0; rst_n = 1'b0;
    tick(); nv += int'(vld[0]);
    tick(); nv += int'(vld[0]);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      nv += int'(vld[0]);
    end
    check("abort_no_valid", nv, 0);
    check("abort_audio_l", int'(aud_l[0]), 0);
    check("abort_audio_r", int'(aud_r[0]), 0);

    // Random traffic: overruns, mute toggles, mode changes, sporadic resets.
    for (int k = 0; k < 3000; k++) begin
      ch_a = 8'($urandom); ch_b = 8'($urandom); ch_c = 8'($urandom);
      if ($urandom_range(0, 49) == 0) stereo = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mute = ~mute;
      ce = 1'($urandom_range(0, 1));
      sce = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
